vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator with a built-in test-pattern source. It drives the board VGA connector, or feeds downstream pixel logic via x/y/de.
Generalises the fixed 800x600@72 (50 MHz) generator in three ways:
- all porch, sync and active widths are parameters;
- sync polarity is configurable, and a pixel clock-enable is added;
- it adds registered, mutually aligned outputs, line and frame strobes, a frame counter, and a selectable pattern with frame-boundary switching.

Parameters:
H_ACTIVE, 800, visible pixels per line
H_FP, 56, horizontal front porch (pixels)
H_SYNC, 120, horizontal sync width (pixels)
H_BP, 64, horizontal back porch (pixels); default H total 1040
V_ACTIVE, 600, visible lines per frame
V_FP, 37, vertical front porch (lines)
V_SYNC, 6, vertical sync width (lines)
V_BP, 23, vertical back porch (lines); default V total 666
HS_POL, 1, h_sync active level
VS_POL, 1, v_sync active level
FCW, 8, frame counter width

Ports:
clk  in  1  system clock (50 MHz default)
rst  in  1  asynchronous active-high reset
pix_ce  in  1  pixel clock-enable; counters and outputs advance only when high
pattern_sel  in  2  0 black, 1 gradient, 2 colour bars, 3 checkerboard
h_sync  out  1  horizontal sync, polarity HS_POL
v_sync  out  1  vertical sync, polarity VS_POL
de  out  1  display enable (active region)
x  out  11  pixel column, 0..H_ACTIVE-1 when de=1
y  out  11  pixel row, 0..V_ACTIVE-1 when de=1
r, g, b  out  4 each  pattern colour; 0 when de=0
line_start  out  1  one-clk strobe at pixel (0,y)
frame_start  out  1  one-clk strobe at pixel (0,0)
frame_cnt  out  FCW  completed-frame counter

Behaviour:
- Counters: h_cnt runs 0..H_TOTAL-1. v_cnt runs 0..V_TOTAL-1.
  - Both advance only on cycles with pix_ce=1.
  - h_cnt wraps to 0 after H_TOTAL-1.
  - v_cnt increments only on the cycle h_cnt wraps; it wraps to 0 after V_TOTAL-1.
- Region order per axis: active [0, ACTIVE), FP, SYNC, BP.
  - Sync is asserted for ACTIVE+FP <= cnt < ACTIVE+FP+SYNC.
  - de = (h_cnt < H_ACTIVE) & (v_cnt < V_ACTIVE).
- Output register: on each pix_ce cycle, all outputs are registered from the current (pre-increment) counter values. Outputs therefore lag the counters by one pixel and are mutually aligned. Outputs hold when pix_ce=0.
- Strobes:
  - line_start is high for exactly one clk, following the pix_ce capture of h_cnt=0 on every line, including blanking lines.
  - frame_start is the same for (0,0).
- frame_cnt increments (wrapping) on the capture of (0,0), excluding the first frame after reset. It therefore reads 1 during frame 2.
- pattern_sel is sampled only at the (0,0) capture. A mid-frame change takes effect at the next frame.
- Patterns (only when de=1; otherwise r=g=b=0):
  - 1 gradient: r=x[3:0], g=y[3:0], b=(x+y) mod 16.
  - 2 colour bars: BAR_W = H_ACTIVE/8 (localparam, floor).
    - A 3-bit bar index i and a sub-counter reset at x=0. i increments each BAR_W pixels and saturates at 7, so the last bar absorbs any remainder.
    - r=~i[1], g=~i[2], b=~i[0], each channel expanded to 4'hF/4'h0. Order: white, yellow, cyan, green, magenta, red, blue, black.
  - 3 checkerboard: all channels 4'hF when x[4]^y[4], else 0.
- Reset (asynchronous, any time including mid-line):
  - counters=0, bar state=0, frame_cnt=0, latched pattern=0;
  - de=0, x=y=0, r=g=b=0, strobes=0, h_sync=~HS_POL, v_sync=~VS_POL.
  - The first pix_ce after release captures (0,0).
- Widths: x/y are 11 bits. Elaboration fails if H_TOTAL or V_TOTAL exceeds 2048.

Decomposition:
- Package vga_pkg: default 800x600@72 timing constants, a pattern_sel enum (PAT_BLACK, PAT_GRAD, PAT_BARS, PAT_CHECK), and an H_TOTAL/V_TOTAL helper function.
- Sub-module vga_axis_counter (params ACTIVE, FP, SYNC, BP, POL): counter with ce and advance inputs. Outputs cnt, wrap, active and sync. Instantiated twice (H, V).

Test Plan:
1. Defaults, pix_ce=1, rst pulse then release.
   - First capture: de=1, x=0, y=0, frame_start=line_start=1 for 1 clk.
   - h_sync high for 120 clk starting 856 clk after the first capture; period 1040.
2. Defaults, run one full frame.
   - v_sync high for 6240 clk (6 lines) beginning at line 637.
   - frame_start period 692640 clk; frame_cnt reads 1 after the second frame_start.
3. pix_ce toggling 1/0.
   - All periods double (h_sync period 2080 clk); outputs stable during pix_ce=0 cycles.
   - Strobes remain 1 clk wide.
4. pattern_sel=2, check line 0.
   - x=99: r=g=b=F. x=100: r=F, g=F, b=0. x=799: r=g=b=0.
   - Switching to 1 at line 300 leaves bars until the next frame_start, then gradient: x=5,y=0 gives r=5, g=0, b=5.
5. rst asserted mid-line (x=400, y=200).
   - Same clk, asynchronously: de=0, h_sync=v_sync inactive, rgb=0.
   - After release, restart at (0,0) with frame_cnt=0.
6. HS_POL=0, VS_POL=0.
   - Idle level 1 after reset; sync pulses low with the same widths as scenario 1.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared timing defaults, pattern selection codes and axis helpers for the VGA generator.
package vga_pkg;

  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_FP     = 56;
  localparam int DEF_H_SYNC   = 120;
  localparam int DEF_H_BP     = 64;
  localparam int DEF_V_ACTIVE = 600;
  localparam int DEF_V_FP     = 37;
  localparam int DEF_V_SYNC   = 6;
  localparam int DEF_V_BP     = 23;

  localparam int MAX_TOTAL = 2048;

  typedef enum logic [1:0] {
    PAT_BLACK = 2'd0,
    PAT_GRAD  = 2'd1,
    PAT_BARS  = 2'd2,
    PAT_CHECK = 2'd3
  } pattern_e;

  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus active/sync decode for that axis.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int   ACTIVE = DEF_H_ACTIVE,
  parameter int   FP     = DEF_H_FP,
  parameter int   SYNC   = DEF_H_SYNC,
  parameter int   BP     = DEF_H_BP,
  parameter logic POL    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        advance,
  output logic [10:0] cnt,
  output logic        wrap,
  output logic        active,
  output logic        sync
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

  generate
    if (TOTAL > MAX_TOTAL || TOTAL < 2) begin : g_bad_total
      $error("vga_axis_counter: axis total %0d outside 2..%0d", TOTAL, MAX_TOTAL);
    end
  endgenerate

  // Compare in 12 bits so a sync window ending exactly at 2048 cannot alias to zero.
  localparam logic [10:0] LAST       = 11'(TOTAL - 1);
  localparam logic [11:0] ACT_END    = 12'(ACTIVE);
  localparam logic [11:0] SYNC_START = 12'(ACTIVE + FP);
  localparam logic [11:0] SYNC_END   = 12'(ACTIVE + FP + SYNC);

  assign wrap   = (cnt == LAST);
  assign active = ({1'b0, cnt} < ACT_END);
  assign sync   = (({1'b0, cnt} >= SYNC_START) && ({1'b0, cnt} < SYNC_END)) ? POL : ~POL;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (ce && advance) begin
      cnt <= wrap ? '0 : cnt + 11'd1;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator with registered, mutually aligned timing, strobes and test patterns.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1,
  parameter int   FCW      = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           pix_ce,
  input  logic [1:0]     pattern_sel,
  output logic           h_sync,
  output logic           v_sync,
  output logic           de,
  output logic [10:0]    x,
  output logic [10:0]    y,
  output logic [3:0]     r,
  output logic [3:0]     g,
  output logic [3:0]     b,
  output logic           line_start,
  output logic           frame_start,
  output logic [FCW-1:0] frame_cnt
);

  localparam int             BAR_W    = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  localparam logic [10:0]    BAR_LAST = 11'(BAR_W - 1);
  localparam logic [FCW-1:0] FC_ONE   = {{(FCW-1){1'b0}}, 1'b1};

  logic [10:0] h_cnt, v_cnt;
  logic        h_wrap, v_wrap, h_act, v_act, h_sync_c, v_sync_c;
  logic [2:0]  bar_idx;
  logic [10:0] bar_sub;
  pattern_e    pat_q, pat_now;
  logic        seen_first;
  logic        at_origin;
  logic [3:0]  r_c, g_c, b_c;

  vga_axis_counter #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL)) u_h_axis (
    .clk(clk), .rst(rst), .ce(pix_ce), .advance(1'b1),
    .cnt(h_cnt), .wrap(h_wrap), .active(h_act), .sync(h_sync_c)
  );

  vga_axis_counter #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL)) u_v_axis (
    .clk(clk), .rst(rst), .ce(pix_ce), .advance(h_wrap),
    .cnt(v_cnt), .wrap(v_wrap), .active(v_act), .sync(v_sync_c)
  );

  assign at_origin = (h_cnt == 11'd0) && (v_cnt == 11'd0);

  // Bar state tracks the current h_cnt, so it restarts whenever the line wraps back to x=0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bar_idx <= '0;
      bar_sub <= '0;
    end else if (pix_ce) begin
      if (h_wrap) begin
        bar_idx <= '0;
        bar_sub <= '0;
      end else if (bar_sub == BAR_LAST) begin
        bar_sub <= '0;
        bar_idx <= (bar_idx == 3'd7) ? 3'd7 : bar_idx + 3'd1;
      end else begin
        bar_sub <= bar_sub + 11'd1;
      end
    end
  end

  // The frame's own first pixel already uses the freshly sampled selection.
  always_comb begin
    pat_now = at_origin ? pattern_e'(pattern_sel) : pat_q;
    r_c = 4'h0;
    g_c = 4'h0;
    b_c = 4'h0;
    if (h_act && v_act) begin
      case (pat_now)
        PAT_GRAD: begin
          r_c = h_cnt[3:0];
          g_c = v_cnt[3:0];
          b_c = h_cnt[3:0] + v_cnt[3:0];
        end
        PAT_BARS: begin
          r_c = {4{~bar_idx[1]}};
          g_c = {4{~bar_idx[2]}};
          b_c = {4{~bar_idx[0]}};
        end
        PAT_CHECK: begin
          r_c = {4{h_cnt[4] ^ v_cnt[4]}};
          g_c = {4{h_cnt[4] ^ v_cnt[4]}};
          b_c = {4{h_cnt[4] ^ v_cnt[4]}};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_sync      <= ~HS_POL;
      v_sync      <= ~VS_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      r           <= '0;
      g           <= '0;
      b           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
      pat_q       <= PAT_BLACK;
      seen_first  <= 1'b0;
    end else if (pix_ce) begin
      h_sync      <= h_sync_c;
      v_sync      <= v_sync_c;
      de          <= h_act && v_act;
      x           <= h_cnt;
      y           <= v_cnt;
      r           <= r_c;
      g           <= g_c;
      b           <= b_c;
      line_start  <= (h_cnt == 11'd0);
      frame_start <= at_origin;
      if (at_origin) begin
        pat_q      <= pat_now;
        seen_first <= 1'b1;
        if (seen_first) frame_cnt <= frame_cnt + FC_ONE;
      end
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised bench comparing vga_timing_gen against a pixel-index model of the raster.
module tb_vga_timing_gen;

  localparam int HA = 42, HF = 4, HS = 6, HB = 5;
  localparam int VA = 20, VF = 2, VS = 3, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FCW = 8;
  localparam int BW = HA / 8;

  logic clk = 1'b0;
  logic rst, pix_ce;
  logic [1:0] pattern_sel;

  logic h_sync, v_sync, de, line_start, frame_start;
  logic [10:0] x, y;
  logic [3:0] r, g, b;
  logic [FCW-1:0] frame_cnt;

  logic h_sync_n, v_sync_n, de_n, line_start_n, frame_start_n;
  logic [10:0] x_n, y_n;
  logic [3:0] r_n, g_n, b_n;
  logic [FCW-1:0] frame_cnt_n;

  vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                   .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                   .HS_POL(1'b1), .VS_POL(1'b1), .FCW(FCW)) dut (
    .clk(clk), .rst(rst), .pix_ce(pix_ce), .pattern_sel(pattern_sel),
    .h_sync(h_sync), .v_sync(v_sync), .de(de), .x(x), .y(y),
    .r(r), .g(g), .b(b), .line_start(line_start), .frame_start(frame_start),
    .frame_cnt(frame_cnt)
  );

  vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                   .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                   .HS_POL(1'b0), .VS_POL(1'b0), .FCW(FCW)) dut_n (
    .clk(clk), .rst(rst), .pix_ce(pix_ce), .pattern_sel(pattern_sel),
    .h_sync(h_sync_n), .v_sync(v_sync_n), .de(de_n), .x(x_n), .y(y_n),
    .r(r_n), .g(g_n), .b(b_n), .line_start(line_start_n), .frame_start(frame_start_n),
    .frame_cnt(frame_cnt_n)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Model state: n counts pixel captures since reset; everything else follows from it.
  int n, cur_pat;
  logic e_hs, e_vs, e_de, e_ls, e_fs;
  int e_x, e_y, e_r, e_g, e_b, e_fc;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    n = 0; cur_pat = 0;
    e_hs = 1'b0; e_vs = 1'b0; e_de = 1'b0; e_ls = 1'b0; e_fs = 1'b0;
    e_x = 0; e_y = 0; e_r = 0; e_g = 0; e_b = 0; e_fc = 0;
  endtask

  task automatic model_capture(input logic ce, input logic [1:0] sel);
    int hx, vy, fr, i;
    if (!ce) begin
      e_ls = 1'b0; e_fs = 1'b0;
      return;
    end
    hx = n % HT;
    vy = (n / HT) % VT;
    fr = n / (HT * VT);
    n++;
    if (hx == 0 && vy == 0) cur_pat = int'(sel);
    e_x = hx; e_y = vy;
    e_de = (hx < HA) && (vy < VA);
    e_hs = (hx >= HA + HF) && (hx < HA + HF + HS);
    e_vs = (vy >= VA + VF) && (vy < VA + VF + VS);
    e_ls = (hx == 0);
    e_fs = (hx == 0) && (vy == 0);
    e_fc = fr % (1 << FCW);
    e_r = 0; e_g = 0; e_b = 0;
    if (e_de) begin
      case (cur_pat)
        1: begin e_r = hx % 16; e_g = vy % 16; e_b = (hx + vy) % 16; end
        2: begin
          i = hx / BW;
          if (i > 7) i = 7;
          e_r = ((i / 2) % 2 == 1) ? 0 : 15;
          e_g = ((i / 4) % 2 == 1) ? 0 : 15;
          e_b = (i % 2 == 1) ? 0 : 15;
        end
        3: begin
          e_r = (((hx / 16) % 2) != ((vy / 16) % 2)) ? 15 : 0;
          e_g = e_r; e_b = e_r;
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_all();
    check_output("h_sync", 32'(h_sync), 32'(e_hs));
    check_output("v_sync", 32'(v_sync), 32'(e_vs));
    check_output("h_sync_lowpol", 32'(h_sync_n), 32'(!e_hs));
    check_output("v_sync_lowpol", 32'(v_sync_n), 32'(!e_vs));
    check_output("de", 32'(de), 32'(e_de));
    check_output("x", 32'(x), 32'(e_x));
    check_output("y", 32'(y), 32'(e_y));
    check_output("rgb", 32'({r, g, b}), 32'(e_r * 256 + e_g * 16 + e_b));
    check_output("line_start", 32'(line_start), 32'(e_ls));
    check_output("frame_start", 32'(frame_start), 32'(e_fs));
    check_output("frame_cnt", 32'(frame_cnt), 32'(e_fc));
  endtask

  task automatic apply_stimulus(input logic ce, input logic [1:0] sel);
    pix_ce = ce;
    pattern_sel = sel;
    model_capture(ce, sel);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    logic [1:0] sel;
    rst = 1'b1; pix_ce = 1'b0; pattern_sel = 2'd0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all();
    rst = 1'b0;

    // Continuous pix_ce: bars for frame 0, switch to gradient mid-frame, visible from frame 1.
    for (int i = 0; i < 2 * HT * VT + 100; i++)
      apply_stimulus(1'b1, (i > HT * 10) ? 2'd1 : 2'd2);

    // Random pix_ce gaps and occasional pattern changes.
    sel = 2'd3;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 99) == 0) sel = 2'($urandom_range(0, 3));
      apply_stimulus($urandom_range(0, 2) != 0, sel);
    end

    // Run to the middle of the active area, then hit reset between clock edges.
    for (int i = 0; i < 2 * HT * VT; i++) begin
      if (e_x == HA / 2 && e_y == VA / 2) break;
      apply_stimulus(1'b1, 2'd2);
    end
    check_output("midline_reached", 32'(e_x == HA / 2 && e_y == VA / 2), 32'd1);
    #2 rst = 1'b1;
    model_reset();
    #1 check_all();
    @(negedge clk);
    check_all();
    rst = 1'b0;

    for (int i = 0; i < HT * VT + 50; i++) apply_stimulus(1'b1, 2'd3);
    for (int i = 0; i < 2500; i++)
      apply_stimulus($urandom_range(0, 1) != 0, 2'($urandom_range(0, 3)));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
